// File: rtl/conv_sequencer.sv
// Control sequencer for a single convolver datapath: weight load, bias load,
// pixel streaming and window-result flagging aligned to the datapath latency.
module conv_sequencer #(
  parameter int DATA_WIDTH   = 16,
  parameter int KERNEL_SIZE  = 5,
  parameter int IMAGE_WIDTH  = 28,
  parameter int IMAGE_HEIGHT = 28,
  parameter int PIPE_LATENCY = 2
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        start,
  input  logic                                        weight_valid,
  output logic                                        weight_ready,
  output logic                                        weight_write,
  output logic [$clog2(KERNEL_SIZE*KERNEL_SIZE)-1:0]  weight_index,
  input  logic                                        bias_valid,
  output logic                                        bias_ready,
  output logic                                        bias_load,
  input  logic                                        pixel_valid,
  output logic                                        pixel_ready,
  output logic                                        shift_en,
  output logic                                        result_valid,
  output logic [$clog2(IMAGE_HEIGHT)-1:0]             out_row,
  output logic [$clog2(IMAGE_WIDTH)-1:0]              out_col,
  output logic                                        busy,
  output logic                                        done
);

  localparam int WI_W = $clog2(KERNEL_SIZE*KERNEL_SIZE);
  localparam int RW   = $clog2(IMAGE_HEIGHT);
  localparam int CW   = $clog2(IMAGE_WIDTH);
  localparam int DR_W = $clog2(PIPE_LATENCY+1);

  localparam logic [WI_W-1:0] W_LAST    = WI_W'(KERNEL_SIZE*KERNEL_SIZE-1);
  localparam logic [RW-1:0]   ROW_LAST  = RW'(IMAGE_HEIGHT-1);
  localparam logic [CW-1:0]   COL_LAST  = CW'(IMAGE_WIDTH-1);
  localparam logic [RW-1:0]   ROW_FIRST = RW'(KERNEL_SIZE-1);
  localparam logic [CW-1:0]   COL_FIRST = CW'(KERNEL_SIZE-1);
  localparam logic [DR_W-1:0] DR_LAST   = DR_W'(PIPE_LATENCY-1);

  if (DATA_WIDTH < 1 || KERNEL_SIZE < 2 || IMAGE_WIDTH < KERNEL_SIZE ||
      IMAGE_HEIGHT < KERNEL_SIZE || PIPE_LATENCY < 1) begin : g_param_check
    $error("conv_sequencer: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_B,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [WI_W-1:0]   widx_q, widx_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [DR_W-1:0]   drain_q, drain_d;

  logic [PIPE_LATENCY-1:0] dv_q;
  logic [RW-1:0]           dr_q [PIPE_LATENCY];
  logic [CW-1:0]           dc_q [PIPE_LATENCY];
  logic                    hit;

  assign weight_ready = (state_q == S_LOAD_W);
  assign bias_ready   = (state_q == S_LOAD_B);
  assign pixel_ready  = (state_q == S_STREAM);
  assign weight_write = weight_valid & weight_ready;
  assign bias_load    = bias_valid & bias_ready;
  assign shift_en     = pixel_valid & pixel_ready;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign weight_index = widx_q;

  assign hit = shift_en && (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);

  assign result_valid = dv_q[PIPE_LATENCY-1];
  assign out_row      = dr_q[PIPE_LATENCY-1];
  assign out_col      = dc_q[PIPE_LATENCY-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      widx_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      row_q   <= row_d;
      col_q   <= col_d;
      drain_q <= drain_d;
    end
  end

  // The last stream acceptance counts as the first latency cycle, so DONE
  // coincides with the final in-flight result.
  always_comb begin
    state_d = state_q;
    widx_d  = widx_q;
    row_d   = row_q;
    col_d   = col_q;
    drain_d = drain_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD_W;
          widx_d  = '0;
          row_d   = '0;
          col_d   = '0;
          drain_d = '0;
        end
      end
      S_LOAD_W: begin
        if (weight_write) begin
          if (widx_q == W_LAST) begin
            widx_d  = '0;
            state_d = S_LOAD_B;
          end else begin
            widx_d = widx_q + WI_W'(1);
          end
        end
      end
      S_LOAD_B: begin
        if (bias_load) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (shift_en) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              drain_d = DR_W'(1);
              state_d = (PIPE_LATENCY == 1) ? S_DONE : S_DRAIN;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (drain_q >= DR_LAST) begin
          drain_d = '0;
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + DR_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Valid bits advance every cycle; coordinates only move with a valid bit,
  // so the last stage holds the most recent result position.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dv_q <= '0;
      for (int unsigned i = 0; i < PIPE_LATENCY; i++) begin
        dr_q[i] <= '0;
        dc_q[i] <= '0;
      end
    end else begin
      dv_q[0] <= hit;
      if (hit) begin
        dr_q[0] <= row_q - ROW_FIRST;
        dc_q[0] <= col_q - COL_FIRST;
      end
      for (int unsigned i = 1; i < PIPE_LATENCY; i++) begin
        dv_q[i] <= dv_q[i-1];
        if (dv_q[i-1]) begin
          dr_q[i] <= dr_q[i-1];
          dc_q[i] <= dc_q[i-1];
        end
      end
    end
  end

endmodule
